// File: rtl/conv_scan_ctrl_pkg.sv
// Shared types for the convolution scan sequencer: FSM states, default widths, tap flags.
// Pure declarations, no logic or latency.
// Optional macro CONV_PAD_EN adds the pad flag to the tap-flags struct.
package conv_pkg;

  localparam int DIM_W_DEF  = 8;
  localparam int K_W_DEF    = 4;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  // Per-tap accumulate control travelling alongside rd_addr.
  typedef struct packed {
    logic clr;
    logic last;
`ifdef CONV_PAD_EN
    logic pad;
`endif
  } tap_flags_t;

endpackage

// File: rtl/conv_scan_ctrl_if.sv
// Bundle between layer control / MAC array and the scan sequencer.
// master = sequencer side, slave = environment side.
// Optional macro CONV_PAD_EN adds the pad signal.
interface conv_scan_ctrl_if
  import conv_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int K_W    = K_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              start;
  logic [DIM_W-1:0]  size;
  logic [K_W-1:0]    ksize;
  logic              tap_ready;
  logic              tap_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              acc_clr;
  logic              acc_last;
  logic [DIM_W-1:0]  out_row;
  logic [DIM_W-1:0]  out_col;
  logic              busy;
  logic              done;
  logic              err;
`ifdef CONV_PAD_EN
  logic              pad;
`endif

  modport master (
    input  start, size, ksize, tap_ready,
    output tap_valid, rd_addr, acc_clr, acc_last, out_row, out_col, busy, done, err
`ifdef CONV_PAD_EN
    , output pad
`endif
  );

  modport slave (
    output start, size, ksize, tap_ready,
    input  tap_valid, rd_addr, acc_clr, acc_last, out_row, out_col, busy, done, err
`ifdef CONV_PAD_EN
    , input pad
`endif
  );

endinterface

// File: rtl/conv_idx_cnt.sv
// Wrapping index counter with runtime limit; exposes next-state value and wrap carry.
// Zero latency on nxt_o/wrap_o (combinational from state and enable).
// Holds while en_i=0; clr_i forces the next value to 0.
module conv_idx_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_lim;

  // Next count: clear, advance-with-wrap, or hold.
  always_comb begin
    at_lim = (({1'b0, cnt_q} + (W+1)'(1)) == {1'b0, limit_i});
    wrap_o = en_i && at_lim && !clr_i;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_lim ? '0 : cnt_q + W'(1);
    end
    nxt_o = cnt_d;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Start/busy/done sequencer walking a KxK window over an NxN map (stride 1), one tap per handshake.
// First tap registered on the start edge; no bubbles while tap_ready stays high.
// Outputs hold while tap_ready=0. Optional macro CONV_PAD_EN: "same" zero-padding with pad output.
module conv_scan_ctrl
  import conv_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int K_W    = K_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               clk,
  input logic               rst,
  conv_scan_ctrl_if.master  bus
);

`ifdef CONV_PAD_EN
  // Extra bit carries the sign of (out + k - P).
  localparam int SW = DIM_W + 2;
`else
  localparam int SW = DIM_W + 1;
`endif

  scan_state_e       state_q, state_d;
  logic [DIM_W-1:0]  n_q, n_d, o_q, o_d;
  logic [K_W-1:0]    k_q, k_d;

  logic              tv_q, tv_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  tap_flags_t        flg_q, flg_d;
  logic [DIM_W-1:0]  row_o_q, row_o_d, col_o_q, col_o_d;

  logic              hs, cnt_clr, illegal;
  logic [DIM_W-1:0]  n_eff;
  logic [K_W-1:0]    k_eff;
  logic [DIM_W:0]    o_calc;
  logic [K_W-1:0]    kc_nxt, kr_nxt;
  logic [DIM_W-1:0]  col_nxt, row_nxt;
  logic              kc_wrap, kr_wrap, col_wrap, row_wrap;
  logic [SW-1:0]     ir, ic;
  logic [ADDR_W-1:0] lin;
`ifdef CONV_PAD_EN
  logic [K_W-1:0]    p_off;
  logic              pad_hit;
`endif

  assign hs      = tv_q && bus.tap_ready;
  assign cnt_clr = (state_q == ST_IDLE);

  // Counter chain kc -> kr -> out_col -> out_row; row carry marks the final tap.
  conv_idx_cnt #(.W(K_W)) u_kc (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(hs), .limit_i(k_q),
    .nxt_o(kc_nxt), .wrap_o(kc_wrap)
  );
  conv_idx_cnt #(.W(K_W)) u_kr (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(kc_wrap), .limit_i(k_q),
    .nxt_o(kr_nxt), .wrap_o(kr_wrap)
  );
  conv_idx_cnt #(.W(DIM_W)) u_col (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(kr_wrap), .limit_i(o_q),
    .nxt_o(col_nxt), .wrap_o(col_wrap)
  );
  conv_idx_cnt #(.W(DIM_W)) u_row (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(col_wrap), .limit_i(o_q),
    .nxt_o(row_nxt), .wrap_o(row_wrap)
  );

  // Parameter decode; in IDLE the live inputs stand in for the not-yet-latched N/K.
  always_comb begin
    n_eff  = (state_q == ST_IDLE) ? bus.size  : n_q;
    k_eff  = (state_q == ST_IDLE) ? bus.ksize : k_q;
`ifdef CONV_PAD_EN
    o_calc = {1'b0, bus.size};
`else
    o_calc = {1'b0, bus.size} - (DIM_W+1)'(bus.ksize) + (DIM_W+1)'(1);
`endif
    illegal = (bus.ksize == '0) || (32'(bus.ksize) > 32'(bus.size)) || o_calc[DIM_W];
`ifdef CONV_PAD_EN
    illegal = illegal || !bus.ksize[0];
`endif
  end

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    o_d     = o_q;
    tv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (illegal) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_SCAN;
            tv_d    = 1'b1;
            busy_d  = 1'b1;
            n_d     = bus.size;
            k_d     = bus.ksize;
            o_d     = o_calc[DIM_W-1:0];
          end
        end
      end
      ST_SCAN: begin
        busy_d = 1'b1;
        tv_d   = 1'b1;
        if (hs && row_wrap) begin
          state_d = ST_DONE;
          tv_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tap address and flags from next-state counters so they line up with tap_valid.
  always_comb begin
`ifdef CONV_PAD_EN
    p_off   = (k_eff - K_W'(1)) >> 1;
    ir      = SW'(row_nxt) + SW'(kr_nxt) - SW'(p_off);
    ic      = SW'(col_nxt) + SW'(kc_nxt) - SW'(p_off);
    pad_hit = ir[SW-1] || (ir >= SW'(n_eff)) || ic[SW-1] || (ic >= SW'(n_eff));
`else
    ir      = SW'(row_nxt) + SW'(kr_nxt);
    ic      = SW'(col_nxt) + SW'(kc_nxt);
`endif
    lin     = ADDR_W'(ir) * ADDR_W'(n_eff) + ADDR_W'(ic);
    addr_d  = '0;
    flg_d   = '0;
    row_o_d = '0;
    col_o_d = '0;
    if (tv_d) begin
      flg_d.clr  = (kr_nxt == '0) && (kc_nxt == '0);
      flg_d.last = (kr_nxt == k_eff - K_W'(1)) && (kc_nxt == k_eff - K_W'(1));
`ifdef CONV_PAD_EN
      flg_d.pad  = pad_hit;
      addr_d     = pad_hit ? '0 : lin;
`else
      addr_d     = lin;
`endif
      row_o_d    = row_nxt;
      col_o_d    = col_nxt;
    end
  end

  // State, latched parameters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      o_q     <= '0;
      tv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      flg_q   <= '0;
      row_o_q <= '0;
      col_o_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      o_q     <= o_d;
      tv_q    <= tv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      flg_q   <= flg_d;
      row_o_q <= row_o_d;
      col_o_q <= col_o_d;
    end
  end

  assign bus.tap_valid = tv_q;
  assign bus.rd_addr   = addr_q;
  assign bus.acc_clr   = flg_q.clr;
  assign bus.acc_last  = flg_q.last;
  assign bus.out_row   = row_o_q;
  assign bus.out_col   = col_o_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
`ifdef CONV_PAD_EN
  assign bus.pad       = flg_q.pad;
`endif

endmodule

// File: doc/conv_scan_ctrl.md
# conv_scan_ctrl

Sequencer for the convolution datapath: on `start` it walks a square K×K kernel window over a square size×size input feature map, stride 1. For every tap it emits a feature-map read address plus accumulate-control flags, using a valid/ready handshake toward the MAC array. It replaces free-running scan counting with a start/busy/done controlled scan and sits between the layer-level control FSM and the feature-map buffer / processing element.

## Interface
- `DIM_W`, 8 — width of map dimension and coordinates
- `K_W`, 4 — width of kernel size
- `ADDR_W`, 16 — width of read address
- `clk` input 1 — clock, rising edge
- `rst` input 1 — reset; asynchronous, active-high
- `start` input 1 — begin a scan; sampled only in IDLE
- `size` input DIM_W — input map dimension N; captured on accepted start
- `ksize` input K_W — kernel dimension K; captured on accepted start
- `tap_ready` input 1 — downstream accepts current tap
- `tap_valid` output 1 — rd_addr and flags valid
- `rd_addr` output ADDR_W — (out_row+kr)*N + (out_col+kc)
- `acc_clr` output 1 — first tap of an output pixel (kr=kc=0)
- `acc_last` output 1 — last tap of an output pixel (kr=kc=K-1)
- `out_row`, `out_col` output DIM_W — current output pixel coordinates
- `busy` output 1 — high from accepted start until done
- `done` output 1 — one-cycle pulse at scan end
- `err` output 1 — parameters illegal; valid while `done` is high

## Operation
- Always: one clock `clk`; reset is asynchronous and active-high (`rst`).
- On `rst`, every output is 0, state is IDLE, and all counters are 0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN when `start`=1 and the parameters are legal. N and K are latched.
  - IDLE → DONE with `err`=1 when K=0 or K>N.
  - SCAN → DONE on the handshake of the final tap.
  - DONE → IDLE unconditionally after one cycle.
- Output dimension O = N−K+1, computed at DIM_W+1 bits.
- Loop order, outermost to innermost: out_row, out_col, kr, kc. Each counter wraps to 0 at its limit: O for out_row/out_col, K for kr/kc.
- Total taps per scan: O·O·K·K.
- Counters advance only on a handshake (`tap_valid`&&`tap_ready`). Outputs hold stable while `tap_ready`=0.
- `rd_addr` arithmetic: row index × N is a full-width product, truncated to ADDR_W. The maximum value 255·255+254 = 65279 fits in 16 bits.
- `start` is ignored while `busy`=1.
- `rst` asserted mid-scan aborts immediately to IDLE. No `done` pulse is produced.
- K=1 is legal: `acc_clr` and `acc_last` are both 1 on every tap. K=N is legal: one output pixel.

## Timing
- `start` sampled high in IDLE at edge n:
  - `busy`=1 and `tap_valid`=1 with the first tap (rd_addr=0, acc_clr=1) from edge n.
  - There are no bubbles: with `tap_ready` held high, one tap is issued per cycle.
- Final handshake at edge m: `tap_valid`=0 and `done`=1 from edge m. `busy` falls at m+1, together with `done`.
- Error path: `done`=1 and `err`=1 one cycle after `start`. `tap_valid` stays 0 throughout.
- All outputs are registered. `rd_addr` is computed from next-state counters so that it aligns with `tap_valid`.

## Configuration
- `CONV_PAD_EN` defined: "same" zero-padding.
  - O = N, with offset P = (K−1)/2.
  - Input coordinate = out + k − P, signed.
  - A new output `pad` is 1 when either coordinate falls outside [0, N−1]; `rd_addr` is 0 in that case.
  - Even K is illegal and sets `err`.
- `CONV_PAD_EN` undefined: the `pad` port is absent, O = N−K+1, and even K is legal.

## Structure
- Shared package `conv_pkg`:
  - FSM state enum
  - DIM_W, K_W, and ADDR_W defaults
  - A tap-flags struct holding clr, last, and pad
- Sub-module `conv_idx_cnt`: a wrapping counter with runtime limit, advance enable, and wrap-out carry. It is instantiated four times and chained through the carries (kc → kr → out_col → out_row).

## Test plan
- N=4, K=3, `tap_ready` always 1 → 36 taps in 36 consecutive cycles. First rd_addr sequence is 0,1,2,4,5,6,8,9,10. `done` is pulsed once.
- N=3, K=3, `tap_ready` toggling every cycle → 9 taps, each held stable while stalled. acc_clr on tap 0, acc_last on tap 8.
- N=2, K=3 → no `tap_valid`. `done`=`err`=1 one cycle after `start`. Also covers K=0.
- `start` re-pulsed mid-scan (N=5, K=2) → ignored. Still exactly 64 taps.
- `rst` asserted at tap 10 → all outputs 0 asynchronously. A subsequent `start` restarts from rd_addr=0.
- `CONV_PAD_EN`, N=3, K=3 → 81 taps. Tap 0 has pad=1 and rd_addr=0; tap 4 (center) has pad=0 and rd_addr=0. K=2 → `err`.
